mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Target-side memory responder for the accumulator CPU's memory bus. The control unit issues word requests as the initiator; this block accepts, executes and acknowledges them.
- Backs a byte-organised array with 16-bit little-endian words: low byte at addr, high byte at addr+1.
- Replaces free-running direct memory wiring with a valid/ready request channel and a valid/ready response channel.
- One instance serves instruction fetch; a second serves data.

Parameters:
- DEPTH, 16384, number of bytes in the array (power of two, ≥ 4).
- ADDR_W, 16, request address width in bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  initiator has a request.
- req_ready  output  1  responder can accept a request; high only in IDLE.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address of the word's low byte.
- req_wdata  input  16  write data; [7:0] goes to addr, [15:8] goes to addr+1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  16  read data; 0 for writes and errors.
- rsp_err  output  1  address out of range; qualified by rsp_valid.

Behaviour:
- Reset, clearing to defaults:
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, internal address/data latches=0.
  - req_ready=1 immediately after reset deasserts.
  - Array contents are not cleared.
- State machine: IDLE -> LO -> HI -> RESP -> IDLE.
- req_ready is combinational: (state==IDLE).
- IDLE: on req_valid && req_ready at edge E0, latch addr, write, wdata.
  - If addr ≥ DEPTH-1, go to RESP with rsp_err=1 and rsp_rdata=0. This covers a word that would straddle or exceed the top; there is no wrap-around.
  - Otherwise go to LO.
- LO (edge E1): read or write byte mem[addr]; go to HI.
- HI (edge E2): read or write byte mem[addr+1]; on reads, load rsp_rdata={mem[addr+1],mem[addr]}; go to RESP.
- RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_valid && rsp_ready at an edge, then go to IDLE with rsp_valid=0.
- Latency:
  - Normal: rsp_valid visible in the cycle after E2, i.e. 3 cycles after the acceptance edge, counting the cycle request is accepted.
  - Error: visible 1 cycle after acceptance.
- Throughput: one request per 4 cycles when rsp_ready is held high.
- Writes also produce a response (rsp_rdata=0, rsp_err=0), so the initiator always sees completion.
- Request inputs are ignored outside IDLE. Initiator must hold req_* stable only until the acceptance edge.
- Back-to-back: req_ready rises in the cycle after the response handshake; there is no same-cycle accept-on-response.
- Read-after-write to the same address returns the new data, since accesses are strictly sequential.
- Odd (unaligned) addresses are legal.
- Reset mid-operation:
  - Abort to IDLE and drop any pending response.
  - If reset hits after E1 of a write, the low byte stays written and the high byte does not. This is defined behaviour.
- X/Z on req_valid while in IDLE is a bench error; the RTL needs no handling for it.

Optional Feature:
- Macro BYTE_ENABLE_EN.
- When defined:
  - Adds input req_be[1:0], latched at acceptance.
  - On writes, be[0] gates the mem[addr] write and be[1] gates the mem[addr+1] write.
  - States LO/HI are still traversed, so timing is unchanged.
  - Reads ignore req_be.
  - be=2'b00 write completes as a no-op with a normal response.
- When undefined: port absent; both bytes are always written.

Decomposition:
- Shared package mem_pkg:
  - State enum {IDLE, LO, HI, RESP}.
  - Default DEPTH and ADDR_W constants.
  - Response encoding (RSP_OK, RSP_ERR).
- Sub-module byte_ram:
  - Single-port, DEPTH×8, synchronous write, registered read.
  - Ports: clk, we, addr, wdata, rdata.
  - No reset on the array.
- The FSM, handshake and word assembly stay in mem_responder.

Test Plan:
- Write 16'hBEEF at addr 0x0010, then read 0x0010 -> rsp_rdata=16'hBEEF; read byte-level: mem[0x10]=8'hEF, mem[0x11]=8'hBE.
- Unaligned: write 16'h1234 at 0x0021, read 0x0020 after 0x0020 holds 16'h00AA -> rdata=16'h34AA.
- Boundary: read at DEPTH-1 (0x3FFF) -> rsp_err=1, rdata=0, rsp_valid 1 cycle after accept, array unchanged; read at 0x3FFE -> rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read response -> rsp_valid and rdata stable, req_ready=0 throughout; handshake -> req_ready=1 next cycle.
- Reset mid-write of 16'hCAFE to 0x0040 (prior 16'h0000), asserted after E1 -> outputs at reset values, req_ready=1; read 0x0040 -> 16'h00FE.
- BYTE_ENABLE_EN: write 16'hAABB with be=2'b10 over 16'h1122 -> read returns 16'hAA22; be=2'b00 -> 16'h1122 unchanged, rsp_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, default sizing,
// and response codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_DEPTH  = 16384;
    localparam int unsigned DEFAULT_ADDR_W = 16;

    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } rsp_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU control unit (master) and a memory
// responder (slave). req_be exists only when BYTE_ENABLE_EN is defined.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
`ifdef BYTE_ENABLE_EN
    logic [1:0]        req_be;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
`ifdef BYTE_ENABLE_EN
        output req_be,
`endif
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
`ifdef BYTE_ENABLE_EN
        input  req_be,
`endif
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_byte_ram.sv
// Single-port byte array: synchronous write, registered (read-first) read.
// The array has no reset.
module byte_ram #(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Write the addressed byte when enabled; always register the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Target-side word memory responder: 16-bit little-endian words over a byte
// array, valid/ready request and response channels, IDLE->LO->HI->RESP FSM.
// Optional byte enables are compiled in with `define BYTE_ENABLE_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int unsigned       AW     = $clog2(DEPTH);
    localparam int unsigned       LAST_I = DEPTH - 1;
    localparam logic [ADDR_W:0]   LAST   = LAST_I[ADDR_W:0];

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [15:0]     wdata_q;
    logic [7:0]      lo_q;
    logic [15:0]     rsp_rdata_q;
    rsp_e            rsp_code_q;
    logic [1:0]      be_q;

    logic            req_ready;
    logic            rsp_valid;
    logic            accept;
    logic            addr_err;
    logic [AW-1:0]   addr_hi;

    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [7:0]      ram_wdata;
    logic [7:0]      ram_rdata;

    assign accept   = bus.req_valid && req_ready;
    assign addr_err = ({1'b0, bus.req_addr} >= LAST);
    assign addr_hi  = addr_q + {{(AW-1){1'b0}}, 1'b1};

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = (rsp_code_q == RSP_ERR);

`ifndef BYTE_ENABLE_EN
    assign be_q = 2'b11;
`endif

    byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and RAM port control.
    // The RAM read is registered, so read addresses run one state ahead:
    // IDLE fetches mem[addr] and LO fetches mem[addr+1], letting HI assemble
    // the full word. Writes still hit mem[addr] in LO and mem[addr+1] in HI.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = bus.req_addr[AW-1:0];
        ram_wdata = wdata_q[7:0];
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = addr_err ? RESP : LO;
                end
            end
            LO: begin
                ram_we    = write_q && be_q[0];
                ram_addr  = write_q ? addr_q : addr_hi;
                ram_wdata = wdata_q[7:0];
                state_d   = HI;
            end
            HI: begin
                ram_we    = write_q && be_q[1];
                ram_addr  = addr_hi;
                ram_wdata = wdata_q[15:8];
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches, low-byte capture and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= RSP_OK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= bus.req_addr[AW-1:0];
                        write_q     <= bus.req_write;
                        wdata_q     <= bus.req_wdata;
                        rsp_rdata_q <= '0;
                        rsp_code_q  <= addr_err ? RSP_ERR : RSP_OK;
                    end
                end
                LO: begin
                    lo_q <= ram_rdata;
                end
                HI: begin
                    if (!write_q) begin
                        rsp_rdata_q <= {ram_rdata, lo_q};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BYTE_ENABLE_EN
    // Byte enables are captured with the rest of the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            be_q <= '0;
        end else if (accept) begin
            be_q <= bus.req_be;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (optionally with
// BYTE_ENABLE_EN defined to exercise byte enables).
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16)) bus ();

    mem_responder #(
        .DEPTH  (16384),
        .ADDR_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a request and hold it until the acceptance edge.
    task automatic send(input logic wr, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Count cycles from acceptance until rsp_valid; lat=1 is the cycle after E0.
    task automatic wait_rsp(output int lat, output logic [15:0] rd, output logic er);
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    task automatic txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic er);
        send(wr, a, d);
        wait_rsp(lat, rd, er);
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [15:0] rd;
    logic        er;

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
`ifdef BYTE_ENABLE_EN
        bus.req_be    = 2'b11;
`endif
        #12;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Aligned write then read back.
        txn(1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
        check("wr_lat",   lat, 32'd3);
        check("wr_rdata", {16'd0, rd}, 32'd0);
        check("wr_err",   {31'd0, er}, 32'd0);
        txn(1'b0, 16'h0010, 16'h0000, lat, rd, er);
        check("rd_lat",   lat, 32'd3);
        check("rd_beef",  {16'd0, rd}, 32'h0000BEEF);
        check("rd_err",   {31'd0, er}, 32'd0);
        check("byte_10",  {24'd0, dut.u_ram.mem[16]}, 32'h000000EF);
        check("byte_11",  {24'd0, dut.u_ram.mem[17]}, 32'h000000BE);

        // Unaligned write overlapping an aligned word.
        txn(1'b1, 16'h0020, 16'h00AA, lat, rd, er);
        txn(1'b1, 16'h0021, 16'h1234, lat, rd, er);
        txn(1'b0, 16'h0020, 16'h0000, lat, rd, er);
        check("unal_rd20", {16'd0, rd}, 32'h000034AA);
        txn(1'b0, 16'h0021, 16'h0000, lat, rd, er);
        check("unal_rd21", {16'd0, rd}, 32'h00001234);

        // Top-of-array boundary.
        txn(1'b1, 16'h3FFE, 16'h5566, lat, rd, er);
        check("top_wr_err", {31'd0, er}, 32'd0);
        txn(1'b0, 16'h3FFF, 16'h0000, lat, rd, er);
        check("err_rd_lat",   lat, 32'd1);
        check("err_rd_err",   {31'd0, er}, 32'd1);
        check("err_rd_rdata", {16'd0, rd}, 32'd0);
        txn(1'b1, 16'h3FFF, 16'hFFFF, lat, rd, er);
        check("err_wr_lat", lat, 32'd1);
        check("err_wr_err", {31'd0, er}, 32'd1);
        txn(1'b0, 16'hFFFF, 16'h0000, lat, rd, er);
        check("err_ffff", {31'd0, er}, 32'd1);
        txn(1'b0, 16'h3FFE, 16'h0000, lat, rd, er);
        check("top_rd_err",   {31'd0, er}, 32'd0);
        check("top_rd_rdata", {16'd0, rd}, 32'h00005566);

        // Backpressure, with a stray request that must be ignored.
        bus.rsp_ready = 1'b0;
        send(1'b0, 16'h0010, 16'h0000);
        wait_rsp(lat, rd, er);
        check("bp_lat",   lat, 32'd3);
        check("bp_first", {16'd0, rd}, 32'h0000BEEF);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0010;
        bus.req_wdata = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid",     {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rdata",     {16'd0, bus.rsp_rdata}, 32'h0000BEEF);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_done_ready", {31'd0, bus.req_ready}, 32'd1);
        txn(1'b0, 16'h0010, 16'h0000, lat, rd, er);
        check("bp_ignored", {16'd0, rd}, 32'h0000BEEF);

        // Reset after the low byte of a write has landed.
        txn(1'b1, 16'h0040, 16'h0000, lat, rd, er);
        send(1'b1, 16'h0040, 16'hCAFE);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        check("mid_rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 16'h0040, 16'h0000, lat, rd, er);
        check("mid_rst_word", {16'd0, rd}, 32'h000000FE);

`ifdef BYTE_ENABLE_EN
        bus.req_be = 2'b11;
        txn(1'b1, 16'h0050, 16'h1122, lat, rd, er);
        bus.req_be = 2'b10;
        txn(1'b1, 16'h0050, 16'hAABB, lat, rd, er);
        bus.req_be = 2'b01;
        txn(1'b0, 16'h0050, 16'h0000, lat, rd, er);
        check("be10_word", {16'd0, rd}, 32'h0000AA22);
        bus.req_be = 2'b11;
        txn(1'b1, 16'h0060, 16'h1122, lat, rd, er);
        bus.req_be = 2'b00;
        txn(1'b1, 16'h0060, 16'h3344, lat, rd, er);
        check("be00_lat", lat, 32'd3);
        check("be00_err", {31'd0, er}, 32'd0);
        txn(1'b0, 16'h0060, 16'h0000, lat, rd, er);
        check("be00_word", {16'd0, rd}, 32'h00001122);
        bus.req_be = 2'b11;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
